// File: rtl/apb_pkg.sv
// apb_pkg: shared APB slave state encoding and default bus widths
package apb_pkg;
  typedef enum logic {IDLE, ACCESS} apb_state_e;
  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
endpackage

// File: rtl/apb_wait_cnt.sv
// apb_wait_cnt: 4-bit wait-state down counter with load, decrement and zero flag
module apb_wait_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 4'd1;
  assign zero = cnt == '0;
endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave with wait states, protocol checking and a flop-array memory
module apb_slave_mem import apb_pkg::*; #(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  apb_state_e state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic write_q, err_q, err_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic cnt_zero, cnt_load, cnt_dec, latch;
  logic [3:0] cnt_val;
  logic setup, access, mismatch, oob, err, commit;
  logic [IDX_W-1:0] idx;
  assign setup    = PSEL && !PENABLE;
  assign access   = state == ACCESS && PSEL && PENABLE;
  assign mismatch = PADDR != addr_q || PWRITE != write_q || PWDATA != wdata_q;
  assign oob      = int'(addr_q) >= DEPTH;
  assign idx      = addr_q[IDX_W-1:0];
  // err_q holds earlier-cycle faults; the live compare catches a change on the completion edge
  assign err      = err_q || oob || mismatch;
  assign PREADY   = access && cnt_zero;
  assign PSLVERR  = PREADY && err;
  assign PRDATA   = PREADY && !err && !write_q ? mem[idx] : '0;
  assign commit   = PREADY && !err && write_q;
  apb_wait_cnt u_wait_cnt (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .load    (cnt_load),
    .load_val(cnt_val),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );
  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    err_nx   = err_q;
    if (state == IDLE) begin
      if (PSEL) begin
        state_nx = ACCESS;
        latch    = setup;
        cnt_load = 1'b1;
        cnt_val  = setup ? WAIT_LD : 4'd0;
        err_nx   = !setup;
      end
    end else if (!PSEL) begin
      state_nx = IDLE;
      cnt_load = 1'b1;
      err_nx   = 1'b0;
    end else if (!PENABLE) begin
      latch    = 1'b1;
      cnt_load = 1'b1;
      cnt_val  = WAIT_LD;
      err_nx   = 1'b0;
    end else if (cnt_zero) begin
      state_nx = IDLE;
      err_nx   = 1'b0;
    end else begin
      cnt_dec = 1'b1;
      err_nx  = err_q || mismatch;
    end
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      if (latch) begin
        addr_q  <= PADDR;
        wdata_q <= PWDATA;
        write_q <= PWRITE;
      end
      if (commit) mem[idx] <= wdata_q;
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: table, directed and random APB transfers against a memory model
module tb_apb_slave_mem;
  logic PCLK = 0, PRESETn = 0, psel = 0, penable = 0, pwrite = 0, which = 0;
  logic [7:0] paddr = 0, pwdata = 0;
  logic [7:0] prdata0, prdata2, prdata;
  logic pready0, pready2, pslverr0, pslverr2, pready, pslverr;
  logic [7:0] model [2][64];
  int vectors = 0, miscompares = 0;
  assign pready  = which ? pready0 : pready2;
  assign pslverr = which ? pslverr0 : pslverr2;
  assign prdata  = which ? prdata0 : prdata2;
  always #5 PCLK = ~PCLK;
  apb_slave_mem #(.WAIT_CYCLES(2)) u_w2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel & ~which), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2));
  apb_slave_mem #(.WAIT_CYCLES(0)) u_w0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel & which), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));
  typedef struct {
    bit       dut;
    bit       w;
    bit [7:0] a;
    bit [7:0] d;
    bit       exp_err;
    bit [7:0] exp_rd;
  } vec_t;
  vec_t tab [12];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) for (int j = 0; j < 64; j++) model[k][j] = 8'h00;
  endtask
  task automatic xfer(input bit w, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic er, output int waits);
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
    @(posedge PCLK); #1 penable = 1; waits = 0;
    @(negedge PCLK);
    while (!pready && waits < 40) begin waits++; @(negedge PCLK); end
    rd = prdata; er = pslverr;
    @(posedge PCLK); #1;
  endtask
  task automatic idle();
    psel = 0; penable = 0;
    @(posedge PCLK); #1;
  endtask
  task automatic wait_ready(output int waits);
    waits = 0;
    @(negedge PCLK);
    while (!pready && waits < 40) begin waits++; @(negedge PCLK); end
  endtask
  task automatic model_xfer(input string nm, input bit w, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rd;
    logic er;
    int wt;
    bit exp_err;
    exp_err = a >= 64;
    xfer(w, a, d, rd, er, wt);
    check({nm, "_err"}, er, exp_err);
    check({nm, "_rd"}, rd, (!w && !exp_err) ? model[which][a[5:0]] : 8'h00);
    check({nm, "_waits"}, wt, which ? 0 : 2);
    if (w && !exp_err) model[which][a[5:0]] = d;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [7:0] rd;
    logic er;
    int wt;
    bit ok;
    tab[0]  = '{0, 1, 8'h05, 8'hA5, 0, 8'h00};
    tab[1]  = '{0, 0, 8'h05, 8'h00, 0, 8'hA5};
    tab[2]  = '{0, 1, 8'h40, 8'h7E, 1, 8'h00};
    tab[3]  = '{0, 0, 8'h00, 8'h00, 0, 8'h00};
    tab[4]  = '{0, 0, 8'h40, 8'h00, 1, 8'h00};
    tab[5]  = '{1, 1, 8'h00, 8'h11, 0, 8'h00};
    tab[6]  = '{1, 1, 8'h01, 8'h22, 0, 8'h00};
    tab[7]  = '{1, 0, 8'h00, 8'h00, 0, 8'h11};
    tab[8]  = '{1, 0, 8'h01, 8'h00, 0, 8'h22};
    tab[9]  = '{0, 1, 8'h3F, 8'hC3, 0, 8'h00};
    tab[10] = '{0, 0, 8'h3F, 8'h00, 0, 8'hC3};
    tab[11] = '{1, 0, 8'h05, 8'h00, 0, 8'h00};
    model_reset();
    #3;
    check("rst_pready", {pready0, pready2}, 2'b00);
    check("rst_pslverr", {pslverr0, pslverr2}, 2'b00);
    check("rst_prdata", {prdata0, prdata2}, 16'h0000);
    @(posedge PCLK); #1 PRESETn = 1;
    @(posedge PCLK); #1;
    for (int i = 0; i < 12; i++) begin
      which = tab[i].dut;
      xfer(tab[i].w, tab[i].a, tab[i].d, rd, er, wt);
      check($sformatf("tab%0d_err", i), er, tab[i].exp_err);
      check($sformatf("tab%0d_rd", i), rd, tab[i].exp_rd);
      check($sformatf("tab%0d_waits", i), wt, tab[i].dut ? 0 : 2);
      if (tab[i].w && !tab[i].exp_err) model[tab[i].dut][tab[i].a[5:0]] = tab[i].d;
    end
    idle();
    which = 0;
    psel = 1; penable = 0; pwrite = 1; paddr = 8'h03; pwdata = 8'h55;
    @(posedge PCLK); #1 penable = 1;
    @(negedge PCLK);
    check("addr_chg_wait", pready, 0);
    @(posedge PCLK); #1 paddr = 8'h04;
    wait_ready(wt);
    check("addr_chg_err", {pready, pslverr}, 2'b11);
    @(posedge PCLK); #1 idle();
    model_xfer("addr_chg_m3", 0, 8'h03, 8'h00);
    model_xfer("addr_chg_m4", 0, 8'h04, 8'h00);
    idle();
    psel = 1; penable = 0; pwrite = 1; paddr = 8'h06; pwdata = 8'h66;
    @(posedge PCLK); #1 penable = 1; pwdata = 8'h67;
    @(posedge PCLK); #1 pwdata = 8'h66;
    wait_ready(wt);
    check("data_glitch_err", {pready, pslverr}, 2'b11);
    @(posedge PCLK); #1 idle();
    model_xfer("data_glitch_m6", 0, 8'h06, 8'h00);
    idle();
    psel = 1; penable = 0; pwrite = 1; paddr = 8'h08; pwdata = 8'h99;
    @(posedge PCLK); #1 penable = 1;
    @(negedge PCLK);
    @(posedge PCLK); #1 psel = 0; penable = 0;
    ok = 1;
    for (int k = 0; k < 4; k++) begin @(negedge PCLK); if (pready) ok = 0; end
    check("abort_no_ready", ok, 1);
    @(posedge PCLK); #1;
    model_xfer("abort_m8", 0, 8'h08, 8'h00);
    idle();
    psel = 1; penable = 1; pwrite = 1; paddr = 8'h09; pwdata = 8'h33;
    @(negedge PCLK);
    check("noset_idle", pready, 0);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("noset_err", {pready, pslverr, prdata}, {2'b11, 8'h00});
    @(posedge PCLK); #1 idle();
    model_xfer("noset_m9", 0, 8'h09, 8'h00);
    which = 1;
    model_xfer("rst_pre_w0", 1, 8'h02, 8'h5A);
    model_xfer("b2b_w0", 0, 8'h02, 8'h00);
    idle();
    which = 0;
    psel = 1; penable = 0; pwrite = 0; paddr = 8'h05; pwdata = 8'h00;
    @(posedge PCLK); #1 penable = 1;
    wait_ready(wt);
    check("rd_before_rst", {pready, prdata}, {1'b1, 8'hA5});
    #2 PRESETn = 0;
    #1 check("async_rst_rd", {pready, pslverr, prdata}, 10'h000);
    psel = 0; penable = 0;
    @(posedge PCLK); #1 PRESETn = 1;
    model_reset();
    model_xfer("pre_ff", 1, 8'h01, 8'h44);
    psel = 1; penable = 0; pwrite = 1; paddr = 8'h02; pwdata = 8'hFF;
    @(posedge PCLK); #1 penable = 1;
    @(negedge PCLK); #2 PRESETn = 0;
    #1 check("async_rst_wr", {pready0, pready2, pslverr0, pslverr2, prdata0, prdata2}, 20'h0);
    psel = 0; penable = 0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1 PRESETn = 1;
    model_reset();
    model_xfer("post_rst_m2", 0, 8'h02, 8'h00);
    model_xfer("post_rst_m1", 0, 8'h01, 8'h00);
    which = 1;
    model_xfer("post_rst_w0", 0, 8'h02, 8'h00);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle();
        which = 1'($urandom_range(0, 1));
      end
      model_xfer($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 79)), 8'($urandom));
    end
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, PADDR width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, PWDATA/PRDATA width in bits.
REQ-003 SHALL have parameter DEPTH, default 64, number of storage words (DEPTH <= 2**ADDR_W).
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, number of PREADY-low cycles inserted per access (0..15).
REQ-005 SHALL have port PCLK, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port PRESETn, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port PSEL, input, 1, slave select from the bridge.
REQ-008 SHALL have port PENABLE, input, 1, access phase indicator.
REQ-009 SHALL have port PWRITE, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port PADDR, input, ADDR_W, word address.
REQ-011 SHALL have port PWDATA, input, DATA_W, write data.
REQ-012 SHALL have port PRDATA, output, DATA_W, read data.
REQ-013 SHALL have port PREADY, output, 1, transfer completion.
REQ-014 SHALL have port PSLVERR, output, 1, transfer error, valid only while PREADY=1.

Function
REQ-015 SHALL implement an FSM with the states IDLE and ACCESS, plus a wait counter cnt (4 bits).
REQ-016 IDLE, on an edge with PSEL=1 and PENABLE=0 (setup): SHALL latch PADDR/PWRITE/PWDATA, load cnt=WAIT_CYCLES, and go to ACCESS.
REQ-017 IDLE, on an edge with PSEL=1 and PENABLE=1 (no prior setup): SHALL go to ACCESS with cnt=0 and the protocol-error flag set.
REQ-018 ACCESS, PSEL=1, PENABLE=1, cnt>0: SHALL decrement cnt and hold PREADY=0.
REQ-019 PREADY SHALL equal (state==ACCESS && cnt==0 && PSEL && PENABLE), decoded from registers and inputs only, so that WAIT_CYCLES=0 gives a zero-wait transfer.
REQ-020 Completion edge (PREADY=1): the write SHALL commit to mem[addr] at that edge only if no error; the FSM returns to IDLE.
REQ-021 Back-to-back: a setup in the cycle after completion SHALL be accepted exactly as from IDLE, with no dead cycle required.
REQ-022 Errors SHALL be: latched addr >= DEPTH; PADDR, PWRITE or PWDATA differing from the latched values during ACCESS; or the REQ-017 case.
REQ-023 On error: PSLVERR=1 with PREADY=1, no memory write, and PRDATA=0.
REQ-024 PRDATA SHALL be mem[addr] while PREADY=1 on an error-free read, and 0 otherwise.
REQ-025 PSEL falling in ACCESS before completion: SHALL abort to IDLE with cnt=0 and no write.
REQ-026 PENABLE=0 with PSEL=1 while in ACCESS: SHALL be treated as a new setup, restarting the access with fresh latches.
REQ-027 PSLVERR SHALL be 0 whenever PREADY=0.

Reset
REQ-028 While PRESETn=0: state=IDLE, cnt=0, latches=0, error flag=0, all memory words=0, PREADY=0, PSLVERR=0, PRDATA=0.
REQ-029 Reset asserted mid-access SHALL abandon the access immediately with no write; the first accepted setup is the one sampled at the first edge after release.

Structure
REQ-030 Shared package apb_pkg SHALL hold the state enum (IDLE, ACCESS) and the default ADDR_W/DATA_W constants, for reuse with master_bridge.
REQ-031 The wait counter SHALL be a sub-module apb_wait_cnt, with load/decrement/zero flag.
REQ-032 Storage SHALL be a flop array inside apb_slave_mem; no other sub-modules.

Verification
REQ-033 WAIT_CYCLES=2: write 0xA5 to addr 0x05, then read 0x05 -> exactly 2 PREADY-low cycles each, PRDATA=0xA5, PSLVERR=0.
REQ-034 WAIT_CYCLES=0: back-to-back writes 0x11@0x00 and 0x22@0x01, then read both -> PREADY=1 in the first ACCESS cycle, reads return 0x11 and 0x22.
REQ-035 Write 0x7E to addr 0x40 (DEPTH=64) -> PREADY=1, PSLVERR=1; a subsequent read of 0x00 returns its prior value.
REQ-036 PADDR changed from 0x03 to 0x04 during the wait cycles of a write of 0x55 -> PSLVERR=1; mem[0x03] and mem[0x04] unchanged.
REQ-037 PSEL dropped after 1 wait cycle of a write of 0x99@0x08 -> no PREADY pulse; a read of 0x08 returns 0x00.
REQ-038 PRESETn pulsed low mid-write of 0xFF@0x02 -> all outputs 0 asynchronously; a read of 0x02 after release returns 0x00.
